user_mgr_arbiter: RTL

Round-robin arbiter that shares the single user-domain OBI manager port toward the Croc subordinate crossbar between NumReq user managers (edge-detection accelerator memory fetch, future DMA, ...).
- Combinational A-channel forwarding.
- An in-order index FIFO routes R-channel responses back to the issuing requester.
- Sits in user_domain between the user managers and user_mgr_obi_req_o / user_mgr_obi_rsp_i.

---
 rtl/user_mgr_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/user_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port between NumReq user managers.
// Optional per-requester grant counters are enabled by defining USER_MGR_ARB_STATS_EN.

package user_mgr_obi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic             req;
    mgr_obi_a_chan_t  a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

module user_mgr_arbiter
  import user_mgr_obi_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned NumMaxTrans = 2,
  parameter type         obi_req_t   = mgr_obi_req_t,
  parameter type         obi_rsp_t   = mgr_obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    sbr_req_i [NumReq],
  output obi_rsp_t    sbr_rsp_o [NumReq],
  output obi_req_t    mgr_req_o,
  input  obi_rsp_t    mgr_rsp_i,
  output logic        busy_o
`ifdef USER_MGR_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt_o [NumReq]
`endif
);

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  localparam int unsigned IdxW = idx_width(NumReq);
  localparam int unsigned PtrW = idx_width(NumMaxTrans);
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(NumMaxTrans - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  idx_t rr_ptr_q, rr_ptr_d;
  idx_t sel_q, sel_d;
  logic lock_q, lock_d;
  idx_t fifo_q [NumMaxTrans];
  idx_t fifo_d [NumMaxTrans];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;

  idx_t arb_idx;
  idx_t sel;
  idx_t head;
  logic sel_req;
  logic full;
  logic empty;
  logic push;
  logic pop;

  // Scan starting at rr_ptr for the first active request.
  always_comb begin : rr_scan
    logic found;
    idx_t cand;
    arb_idx = rr_ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = idx_t'((32'(rr_ptr_q) + k) % NumReq);
      if (!found && sbr_req_i[cand].req) begin
        found   = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign sel     = lock_q ? sel_q : arb_idx;
  assign sel_req = sbr_req_i[sel].req;
  assign full    = (count_q == cnt_t'(NumMaxTrans));
  assign empty   = (count_q == '0);
  assign head    = fifo_q[rd_ptr_q];
  assign push    = mgr_req_o.req & mgr_rsp_i.gnt;
  assign pop     = rst_ni & mgr_rsp_i.rvalid & ~empty;
  assign busy_o  = ~empty;

  always_comb begin
    mgr_req_o = '0;
    if (rst_ni && sel_req) begin
      mgr_req_o.a   = sbr_req_i[sel].a;
      mgr_req_o.req = ~full;
    end
  end

  // R payload is broadcast; only the FIFO head sees rvalid.
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      sbr_rsp_o[i]        = '0;
      sbr_rsp_o[i].r      = mgr_rsp_i.r;
      sbr_rsp_o[i].gnt    = push & (sel == idx_t'(i));
      sbr_rsp_o[i].rvalid = pop & (head == idx_t'(i));
    end
  end

  always_comb begin
    sel_d    = sel;
    lock_d   = sel_req & ~push;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (sel == idx_t'(NumReq - 1)) ? '0 : sel + idx_t'(1);
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < NumMaxTrans; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
    end
  end

`ifdef USER_MGR_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NumReq];
  logic [15:0] grant_cnt_d [NumReq];

  // Saturating per-requester handshake counters.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (push && (sel == idx_t'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

`ifndef SYNTHESIS
  rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      mgr_rsp_i.rvalid |-> !empty)
    else $warning("user_mgr_arbiter: rvalid with no outstanding transaction dropped");

  locked_req_dropped: assert property (@(posedge clk_i) disable iff (!rst_ni)
      lock_q |-> sbr_req_i[sel_q].req)
    else $warning("user_mgr_arbiter: locked requester withdrew its request");
`endif

endmodule
